pipeline_hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the 5-stage pipeline. It watches the ID, ID/EX and EX/MEM stage contents and drives the write-enable, hold and flush controls of the PC and the IF/ID, ID/EX and EX/MEM pipeline registers. It resolves four cases: load-use stalls, taken branches resolved in MEM, variable-latency data-memory waits, and post-reset pipeline clearing. It also keeps stall/flush performance counters and a memory-timeout watchdog.

---
 rtl/pipeline_hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: hazard and sequencing controller for a 5-stage pipeline.
//
// Resolves load-use stalls, taken branches resolved in MEM, variable-latency
// data-memory waits and post-reset pipeline clearing. Also keeps saturating
// stall/flush counters and a sticky memory-timeout watchdog.
//
// Parameters:
//     INIT_CYCLES  cycles of forced flush after reset release (1..15)
//     MEM_TIMEOUT  max consecutive memory-wait cycles before error (2..255)
// Ports:
//     i_clk, i_rst                  clock, async active-high reset
//     i_id_rs/rt, i_id_uses_rs/rt   ID-stage source registers and their use
//     i_ex_mem2reg_sel/_reg_write_en/_reg_wb_addr  ID/EX writeback info (01 = load)
//     i_mem_beq/_bne/_zero_flag     EX/MEM branch controls and zero flag
//     i_mem_mem_access, i_mem_ready EX/MEM memory access and memory completion
//     o_pc_write_en, o_ifid_write_en, o_pipe_hold   register update/hold controls
//     o_ifid_flush, o_idex_flush, o_exmem_flush     bubble insertion
//     o_branch_taken                PC selects branch target
//     o_mem_timeout                 sticky watchdog error
//     o_stall_count, o_flush_count  saturating performance counters
module pipeline_hazard_ctrl #(
    parameter int INIT_CYCLES = 2,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [4:0]  i_id_rs,
    input  logic [4:0]  i_id_rt,
    input  logic        i_id_uses_rs,
    input  logic        i_id_uses_rt,
    input  logic [1:0]  i_ex_mem2reg_sel,
    input  logic        i_ex_reg_write_en,
    input  logic [4:0]  i_ex_reg_wb_addr,
    input  logic        i_mem_beq,
    input  logic        i_mem_bne,
    input  logic        i_mem_zero_flag,
    input  logic        i_mem_mem_access,
    input  logic        i_mem_ready,
    output logic        o_pc_write_en,
    output logic        o_ifid_write_en,
    output logic        o_pipe_hold,
    output logic        o_ifid_flush,
    output logic        o_idex_flush,
    output logic        o_exmem_flush,
    output logic        o_branch_taken,
    output logic        o_mem_timeout,
    output logic [15:0] o_stall_count,
    output logic [15:0] o_flush_count
);
    typedef enum logic [1:0] {S_INIT, S_RUN, S_MEM_WAIT, S_ERROR} state_t;

    state_t      r_state, w_next_state;
    logic [3:0]  r_init_cnt;
    logic [7:0]  r_wait_cnt;
    logic [15:0] r_stall_cnt, r_flush_cnt;
    logic        w_taken, w_loaduse, w_memstall, w_hold, w_active;

    assign w_taken    = (i_mem_beq & i_mem_zero_flag) | (i_mem_bne & ~i_mem_zero_flag);
    assign w_loaduse  = (i_ex_mem2reg_sel == 2'b01) & i_ex_reg_write_en & (i_ex_reg_wb_addr != 5'd0) &
                        ((i_id_uses_rs & (i_id_rs == i_ex_reg_wb_addr)) |
                         (i_id_uses_rt & (i_id_rt == i_ex_reg_wb_addr)));
    assign w_memstall = i_mem_mem_access & ~i_mem_ready;
    // Once waiting, only MemReady releases the hold, whatever MemAccess does.
    assign w_hold     = (r_state == S_MEM_WAIT) ? ~i_mem_ready : w_memstall;
    assign w_active   = (r_state == S_RUN) | (r_state == S_MEM_WAIT);

    assign o_mem_timeout = (r_state == S_ERROR);
    assign o_stall_count = r_stall_cnt;
    assign o_flush_count = r_flush_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_INIT;
            r_init_cnt  <= '0;
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_INIT)
                r_init_cnt <= r_init_cnt + 4'd1;
            // Loading 1 every RUN cycle means the first memstall cycle is already counted.
            if (r_state == S_RUN)
                r_wait_cnt <= 8'd1;
            else if (r_state == S_MEM_WAIT)
                r_wait_cnt <= r_wait_cnt + 8'd1;
            if (w_active && !o_pc_write_en && r_stall_cnt != 16'hFFFF)
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if (o_branch_taken && r_flush_cnt != 16'hFFFF)
                r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        o_pc_write_en   = 1'b0;
        o_ifid_write_en = 1'b0;
        o_pipe_hold     = 1'b0;
        o_ifid_flush    = 1'b0;
        o_idex_flush    = 1'b0;
        o_exmem_flush   = 1'b0;
        o_branch_taken  = 1'b0;
        case (r_state)
            S_INIT: begin
                o_ifid_flush  = 1'b1;
                o_idex_flush  = 1'b1;
                o_exmem_flush = 1'b1;
                if (r_init_cnt == 4'(INIT_CYCLES - 1))
                    w_next_state = S_RUN;
            end
            S_RUN, S_MEM_WAIT: begin
                if (w_hold) begin
                    o_pipe_hold  = 1'b1;
                    w_next_state = (r_state == S_MEM_WAIT && r_wait_cnt == 8'(MEM_TIMEOUT - 1)) ? S_ERROR : S_MEM_WAIT;
                end else begin
                    w_next_state = S_RUN;
                    // A taken branch flushes the dependent instruction, so it beats load-use.
                    if (w_taken) begin
                        o_branch_taken  = 1'b1;
                        o_pc_write_en   = 1'b1;
                        o_ifid_write_en = 1'b1;
                        o_ifid_flush    = 1'b1;
                        o_idex_flush    = 1'b1;
                        o_exmem_flush   = 1'b1;
                    end else if (w_loaduse) begin
                        o_idex_flush = 1'b1;
                    end else begin
                        o_pc_write_en   = 1'b1;
                        o_ifid_write_en = 1'b1;
                    end
                end
            end
            default: o_pipe_hold = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: randomized and directed checks of pipeline_hazard_ctrl against a behavioural model.
module tb_pipeline_hazard_ctrl;
    localparam int INIT_CYCLES = 2;
    localparam int MEM_TIMEOUT = 6;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [4:0]  i_id_rs = '0, i_id_rt = '0, i_ex_reg_wb_addr = '0;
    logic        i_id_uses_rs = 0, i_id_uses_rt = 0, i_ex_reg_write_en = 0;
    logic [1:0]  i_ex_mem2reg_sel = '0;
    logic        i_mem_beq = 0, i_mem_bne = 0, i_mem_zero_flag = 0, i_mem_mem_access = 0, i_mem_ready = 0;
    logic        o_pc_write_en, o_ifid_write_en, o_pipe_hold, o_ifid_flush, o_idex_flush, o_exmem_flush;
    logic        o_branch_taken, o_mem_timeout;
    logic [15:0] o_stall_count, o_flush_count;

    int n_cmp = 0, n_err = 0;
    int m_init_left, m_stalled, m_stalls, m_flushes;
    bit m_wait, m_err;

    pipeline_hazard_ctrl #(.INIT_CYCLES(INIT_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_id_rs(i_id_rs), .i_id_rt(i_id_rt), .i_id_uses_rs(i_id_uses_rs), .i_id_uses_rt(i_id_uses_rt),
        .i_ex_mem2reg_sel(i_ex_mem2reg_sel), .i_ex_reg_write_en(i_ex_reg_write_en), .i_ex_reg_wb_addr(i_ex_reg_wb_addr),
        .i_mem_beq(i_mem_beq), .i_mem_bne(i_mem_bne), .i_mem_zero_flag(i_mem_zero_flag),
        .i_mem_mem_access(i_mem_mem_access), .i_mem_ready(i_mem_ready),
        .o_pc_write_en(o_pc_write_en), .o_ifid_write_en(o_ifid_write_en), .o_pipe_hold(o_pipe_hold),
        .o_ifid_flush(o_ifid_flush), .o_idex_flush(o_idex_flush), .o_exmem_flush(o_exmem_flush),
        .o_branch_taken(o_branch_taken), .o_mem_timeout(o_mem_timeout),
        .o_stall_count(o_stall_count), .o_flush_count(o_flush_count)
    );

    always #5 clk = ~clk;

    // {pc_we, ifid_we, hold, ifid_flush, idex_flush, exmem_flush, branch_taken, timeout}
    function automatic logic [7:0] ctl();
        return {o_pc_write_en, o_ifid_write_en, o_pipe_hold, o_ifid_flush, o_idex_flush, o_exmem_flush, o_branch_taken, o_mem_timeout};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_idle();
        {i_id_rs, i_id_rt, i_ex_reg_wb_addr} = '0;
        {i_id_uses_rs, i_id_uses_rt, i_ex_reg_write_en, i_ex_mem2reg_sel} = '0;
        {i_mem_beq, i_mem_bne, i_mem_zero_flag, i_mem_mem_access} = '0;
        i_mem_ready = 1'b1;
    endtask

    // Called just after a rising edge; reset is applied asynchronously here.
    task automatic do_reset();
        i_rst = 1'b1;
        m_init_left = INIT_CYCLES;
        m_wait = 0; m_err = 0; m_stalled = 0; m_stalls = 0; m_flushes = 0;
        @(negedge clk);
        check("rst_ctl", 32'(ctl()), 32'h1C);
        check("rst_stall", 32'(o_stall_count), 0);
        check("rst_flush", 32'(o_flush_count), 0);
        @(posedge clk);
        #1 i_rst = 1'b0;
    endtask

    // One clock cycle: predict outputs from the rules, compare mid-cycle, then advance the model.
    task automatic cycle(input bit chk);
        bit tk, lu, hold_c;
        logic [7:0] e;
        @(negedge clk);
        tk = (i_mem_beq && i_mem_zero_flag) || (i_mem_bne && !i_mem_zero_flag);
        lu = i_ex_mem2reg_sel == 2'b01 && i_ex_reg_write_en && i_ex_reg_wb_addr != 0 &&
             ((i_id_uses_rs && i_id_rs == i_ex_reg_wb_addr) || (i_id_uses_rt && i_id_rt == i_ex_reg_wb_addr));
        hold_c = m_wait ? !i_mem_ready : (i_mem_mem_access && !i_mem_ready);
        if (m_init_left > 0)  e = 8'b00011100;
        else if (m_err)       e = 8'b00100001;
        else if (hold_c)      e = 8'b00100000;
        else if (tk)          e = 8'b11011110;
        else if (lu)          e = 8'b00001000;
        else                  e = 8'b11000000;
        if (chk) begin
            check("ctl", 32'(ctl()), 32'(e));
            check("stall", 32'(o_stall_count), m_stalls);
            check("flush", 32'(o_flush_count), m_flushes);
        end
        @(posedge clk);
        if (m_init_left > 0) m_init_left--;
        else if (!m_err) begin
            if (!e[7] && m_stalls < 65535) m_stalls++;
            if (e[1] && m_flushes < 65535) m_flushes++;
            if (hold_c) begin
                m_stalled++;
                if (m_stalled == MEM_TIMEOUT) m_err = 1;
                else m_wait = 1;
            end else begin
                m_wait = 0;
                m_stalled = 0;
            end
        end
        #1;
    endtask

    initial begin
        set_idle();
        @(posedge clk); #1;
        // reset release and init flush window
        do_reset();
        repeat (4) cycle(1);
        // load-use on Rt, then load moves on; then same with $0 destination
        i_ex_mem2reg_sel = 2'b01; i_ex_reg_write_en = 1; i_ex_reg_wb_addr = 5; i_id_rt = 5; i_id_uses_rt = 1;
        cycle(1);
        i_ex_mem2reg_sel = 2'b00; i_ex_reg_write_en = 0;
        cycle(1);
        check("lu_stall", 32'(o_stall_count), 1);
        i_ex_mem2reg_sel = 2'b01; i_ex_reg_write_en = 1; i_ex_reg_wb_addr = 0; i_id_rt = 0;
        cycle(1); cycle(1);
        check("lu_r0", 32'(o_stall_count), 1);
        // beq taken, then bne with zero (not taken)
        set_idle();
        i_mem_beq = 1; i_mem_zero_flag = 1;
        cycle(1);
        i_mem_beq = 0; i_mem_bne = 1;
        cycle(1);
        check("br_flush", 32'(o_flush_count), 1);
        // memory wait of 5 cycles with a pending taken branch
        set_idle();
        do_reset();
        repeat (3) cycle(1);
        i_mem_mem_access = 1; i_mem_ready = 0; i_mem_beq = 1; i_mem_zero_flag = 1;
        repeat (5) cycle(1);
        check("mw_flush0", 32'(o_flush_count), 0);
        i_mem_ready = 1;
        cycle(1);
        set_idle();
        cycle(1);
        check("mw_stall", 32'(o_stall_count), 5);
        check("mw_flush", 32'(o_flush_count), 1);
        // watchdog timeout
        i_mem_mem_access = 1; i_mem_ready = 0;
        repeat (MEM_TIMEOUT) cycle(1);
        check("timeout", 32'(o_mem_timeout), 1);
        i_mem_ready = 1;
        repeat (3) cycle(1);
        set_idle();
        do_reset();
        // randomized traffic with occasional asynchronous resets
        for (int k = 0; k < 3000; k++) begin
            if ((m_err && $urandom_range(3) == 0) || $urandom_range(299) == 0) begin
                do_reset();
            end else begin
                i_id_rs = 5'($urandom_range(3));
                i_id_rt = 5'($urandom_range(3));
                i_ex_reg_wb_addr = 5'($urandom_range(3));
                i_id_uses_rs = 1'($urandom_range(1));
                i_id_uses_rt = 1'($urandom_range(1));
                i_ex_mem2reg_sel = 2'($urandom_range(3));
                i_ex_reg_write_en = 1'($urandom_range(1));
                i_mem_beq = ($urandom_range(3) == 0);
                i_mem_bne = ($urandom_range(3) == 0);
                i_mem_zero_flag = 1'($urandom_range(1));
                i_mem_mem_access = ($urandom_range(2) == 0);
                i_mem_ready = 1'($urandom_range(1));
                cycle(1);
            end
        end
        // stall counter saturation
        set_idle();
        do_reset();
        i_ex_mem2reg_sel = 2'b01; i_ex_reg_write_en = 1; i_ex_reg_wb_addr = 7; i_id_rs = 7; i_id_uses_rs = 1;
        repeat (65540) cycle(0);
        cycle(1);
        check("sat", 32'(o_stall_count), 32'hFFFF);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
